seg_display_scheduler: RTL
==========================

# seg_display_scheduler

Time-shares the 8-digit seven-segment display between up to `N_SRC` 32-bit debug sources, such as PC, ALU result or a selected register. Each requester gets the display for a fixed minimum slot, and sources are served round-robin. The block sits between the CPU/debug datapath and the segment driver, which scans `value` out to the digits. Its outputs are registered so the driver always sees a stable word for the whole slot.

## Interface
- `N_SRC`, default 4: number of requesters, 2..8.
- `HOLD_CYCLES`, default 50_000_000: slot length in `clk` cycles, ≥1.
- `LIVE`, default 1: selects how `value` is driven during a slot.
  - 1: `value` tracks the granted source's data every cycle.
  - 0: `value` is a snapshot taken at grant.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input N_SRC: per-source display request; level, sampled every cycle.
- `data` input 32*N_SRC: source i occupies bits [32*i+31:32*i].
- `freeze` input 1: when high, pauses the slot counter and holds the current owner.
- `value` output 32: word sent to the segment driver.
- `grant` output N_SRC: one-hot current owner; all zero when idle.
- `cur_src` output $clog2(N_SRC): index of the current or most recent owner.
- `slot_start` output 1: one-cycle pulse on the first cycle of every slot.
- `busy` output 1: high while a slot is active.

## Operation
- **States:** IDLE and SHOW.
- **Reset values:**
  - State is IDLE.
  - `value`=0, `grant`=0, `cur_src`=0, `slot_start`=0, `busy`=0.
  - Slot counter is 0.
  - Round-robin pointer `last`=N_SRC-1, so source 0 has first priority after reset.
- **Arbitration:**
  - Search `req` from index `last`+1 upward, wrapping modulo N_SRC.
  - The first set bit wins.
  - `last` updates to the winner at grant.
- **IDLE:**
  - If `req`≠0, the next edge enters SHOW:
    - Set `grant` to the winner.
    - Set `cur_src` to the winner.
    - Load the counter with HOLD_CYCLES-1.
    - Set `slot_start`=1 and `busy`=1.
    - Load `value` from the winner's data.
  - If `req`=0, remain in IDLE; `value` and `cur_src` keep the last shown word and index.
- **SHOW:**
  - While `freeze`=1: counter holds, `grant` holds; with LIVE=1, `value` still tracks the source.
  - While `freeze`=0 and counter>0: counter decrements by 1 per cycle.
  - When `freeze`=0 and counter=0, the slot ends and re-arbitration happens on that same edge with no gap cycle:
    - If any `req` bit is set, the new winner is granted immediately with the same actions as IDLE→SHOW, including `slot_start`.
    - A sole requester is re-granted to itself and gets a new `slot_start`.
    - If `req`=0, go to IDLE: `grant`=0, `busy`=0, and `value`/`cur_src` hold.
- **Owner drops `req` mid-slot:** the slot still runs to completion (minimum display time guaranteed).
- **Value in SHOW:**
  - LIVE=1: `value` is registered from `data[cur_src]` every cycle, one cycle of lag.
  - LIVE=0: `value` is loaded only at grant.
- **Counter width:** max(1, $clog2(HOLD_CYCLES)).
- **HOLD_CYCLES=1:** every slot lasts exactly one cycle; `slot_start` is then high on every cycle while requests persist.
- **Reset mid-slot:** everything returns to its reset value immediately and asynchronously; the next grant starts from source 0.

## Timing
- Grant latency: 1 cycle from `req` rising (while IDLE) to `grant`/`slot_start`/`value` valid.
- Slot length with `freeze`=0: exactly HOLD_CYCLES cycles of `grant` asserted, then either the next `grant` on the following cycle or IDLE.
- Each cycle of `freeze`=1 during SHOW extends the slot by one cycle.
- `slot_start` is high for exactly one cycle per slot, coincident with the first cycle of the new `grant`.
- All outputs are registered; there is no combinational path from `req`/`data` to any output.
- Simultaneous `req` changes and slot end: the arbiter uses `req` as sampled on the ending edge.

## Test plan
Bench settings: N_SRC=4, HOLD_CYCLES=4.
- **Reset then single request:** hold `req`=0001 with data0=0x12345678. Expect `grant`=0001 and `value`=0x12345678 one cycle later; `slot_start` pulses every 4 cycles while `req` is held.
- **Round-robin:** hold `req`=1011. Expect the grant sequence 0→1→3→0, each owner held 4 cycles, with no idle cycles between slots.
- **Drop mid-slot:** raise `req`=0100 for 1 cycle only. Expect `grant`=0100 for 4 cycles, then IDLE with `busy`=0 and `value` retaining data2.
- **Freeze:** assert `freeze` for 3 cycles in the middle of a slot. Expect that slot to last 7 cycles in total, while LIVE=1 `value` follows a changing data0 (0x1→0x2 shows 0x2 one cycle later).
- **LIVE=0 snapshot:** change the owner's data after grant. Expect `value` to stay at the grant-time word until the next slot.
- **Async reset mid-slot:** pulse `rst` between edges. Expect all outputs 0 immediately; with `req`=1111 afterwards, the first grant goes to source 0.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin time-sharing of the seven-segment display
// between N_SRC 32-bit debug sources, each owner holding it for a minimum slot.
module seg_display_scheduler #(
   parameter int N_SRC       = 4,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter bit LIVE        = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_SRC-1:0]         req,
   input  logic [32*N_SRC-1:0]      data,
   input  logic                     freeze,
   output logic [31:0]              value,
   output logic [N_SRC-1:0]         grant,
   output logic [$clog2(N_SRC)-1:0] cur_src,
   output logic                     slot_start,
   output logic                     busy
);
   localparam int IW = $clog2(N_SRC);
   localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   typedef enum logic {IDLE, SHOW} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] last, win;
   logic          found, rearb;
   logic [31:0]   src [N_SRC];
   for (genvar i = 0; i < N_SRC; i++) assign src[i] = data[32*i +: 32];
   // search starts just past the previous winner so every requester gets a turn
   always_comb begin
      win   = last;
      found = 1'b0;
      for (int k = 1; k <= N_SRC; k++)
         if (!found && req[(int'(last) + k) % N_SRC]) begin
            win   = IW'((int'(last) + k) % N_SRC);
            found = 1'b1;
         end
   end
   assign rearb = state == IDLE || (!freeze && cnt == '0);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last       <= IW'(N_SRC - 1);
         value      <= '0;
         grant      <= '0;
         cur_src    <= '0;
         slot_start <= 1'b0;
         busy       <= 1'b0;
      end else begin
         slot_start <= 1'b0;
         if (rearb) begin
            if (found) begin
               state      <= SHOW;
               grant      <= N_SRC'(1) << win;
               cur_src    <= win;
               last       <= win;
               cnt        <= CW'(HOLD_CYCLES - 1);
               slot_start <= 1'b1;
               busy       <= 1'b1;
               value      <= src[win];
            end else begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         end else begin
            if (!freeze) cnt <= cnt - 1'b1;
            if (LIVE) value <= src[cur_src];
         end
      end
   end
endmodule
